// File: rtl/lcd_win_if.sv
// Command/pixel bus between the window controller and whoever feeds it.
// The master drives commands and pixels; the slave returns the window stream.
interface lcd_win_if #(
  parameter int DW = 8
);
  logic [DW-1:0] datain;
  logic [3:0]    cmd;
  logic          cmd_valid;
  logic [DW-1:0] dataout;
  logic          output_valid;
  logic          busy;
  logic          zoom_mode;

  modport master (
    output datain, cmd, cmd_valid,
    input  dataout, output_valid, busy, zoom_mode
  );

  modport slave (
    input  datain, cmd, cmd_valid,
    output dataout, output_valid, busy, zoom_mode
  );
endinterface

// File: rtl/lcd_win_ctrl.sv
// Image buffer plus WIN x WIN window streamer with fit/zoom views and mirroring.
//   state | meaning
//   IDLE  | waiting for cmd_valid
//   LOAD  | writing IMG_W*IMG_H raster pixels into the buffer
//   EXEC  | one cycle applying a view/move/mirror command
//   OUT   | streaming WIN*WIN pixels, then one closing cycle
module lcd_win_ctrl #(
  parameter int IMG_W = 12,
  parameter int IMG_H = 9,
  parameter int WIN   = 4,
  parameter int DW    = 8
) (
  input logic clk,
  input logic reset,
  lcd_win_if.slave bus
);
  localparam int NPIX = IMG_W * IMG_H;
  localparam int AW   = $clog2(NPIX);
  localparam int OW   = $clog2((IMG_W > IMG_H) ? IMG_W : IMG_H);
  localparam int WB   = $clog2(WIN);
  localparam int IW   = 2 * WB + 1;
  localparam int SX   = IMG_W / WIN;
  localparam int SY   = IMG_H / WIN;

  localparam logic [OW-1:0] OX0    = OW'((IMG_W - WIN + 1) / 2);
  localparam logic [OW-1:0] OY0    = OW'((IMG_H - WIN + 1) / 2);
  localparam logic [OW-1:0] OX_MAX = OW'(IMG_W - WIN);
  localparam logic [OW-1:0] OY_MAX = OW'(IMG_H - WIN);
  localparam logic [IW-1:0] NOUT   = IW'(WIN * WIN);
  localparam logic [AW-1:0] LAST   = AW'(NPIX - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EXEC, S_OUT} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cmd_q;
  logic [AW-1:0] wr_addr;
  logic [IW-1:0] idx;
  logic [OW-1:0] ox, oy;
  logic          zoom, mirror_h, mirror_v;
  logic [DW-1:0] dataout_q;
  logic          valid_q, busy_q;
  logic [DW-1:0] mem [NPIX];

  logic [WB-1:0] r_eff, c_eff;
  logic [AW-1:0] row_a, col_a, rd_addr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.cmd_valid) state_d = (bus.cmd == 4'd0) ? S_LOAD : S_EXEC;
      S_LOAD: if (wr_addr == LAST) state_d = S_OUT;
      S_EXEC: state_d = S_OUT;
      S_OUT:  if (idx == NOUT) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // WIN is a power of two, so WIN-1-x is just the bitwise complement.
  always_comb begin
    r_eff = mirror_v ? ~idx[2*WB-1:WB] : idx[2*WB-1:WB];
    c_eff = mirror_h ? ~idx[WB-1:0]    : idx[WB-1:0];
    if (zoom) begin
      row_a = AW'(oy) + AW'(r_eff);
      col_a = AW'(ox) + AW'(c_eff);
    end else begin
      row_a = AW'(r_eff) * AW'(SY) + AW'(SY / 2);
      col_a = AW'(c_eff) * AW'(SX) + AW'(SX / 2);
    end
    rd_addr = row_a * AW'(IMG_W) + col_a;
  end

  always_ff @(posedge clk) begin
    if (state_q == S_LOAD) mem[wr_addr] <= bus.datain;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_q     <= '0;
      wr_addr   <= '0;
      idx       <= '0;
      ox        <= OX0;
      oy        <= OY0;
      zoom      <= 1'b0;
      mirror_h  <= 1'b0;
      mirror_v  <= 1'b0;
      dataout_q <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            cmd_q   <= bus.cmd;
            busy_q  <= 1'b1;
            wr_addr <= '0;
            idx     <= '0;
          end
        end
        S_LOAD: begin
          wr_addr <= wr_addr + AW'(1);
          if (wr_addr == LAST) begin
            zoom     <= 1'b0;
            mirror_h <= 1'b0;
            mirror_v <= 1'b0;
            ox       <= OX0;
            oy       <= OY0;
          end
        end
        S_EXEC: begin
          case (cmd_q)
            4'd1: if (!zoom) begin
              zoom <= 1'b1;
              ox   <= OX0;
              oy   <= OY0;
            end
            4'd2: zoom <= 1'b0;
            4'd3: if (zoom && ox != OX_MAX) ox <= ox + OW'(1);
            4'd4: if (zoom && ox != '0)     ox <= ox - OW'(1);
            4'd5: if (zoom && oy != '0)     oy <= oy - OW'(1);
            4'd6: if (zoom && oy != OY_MAX) oy <= oy + OW'(1);
            4'd8: mirror_h <= ~mirror_h;
            4'd9: mirror_v <= ~mirror_v;
            default: ;
          endcase
        end
        S_OUT: begin
          if (idx == NOUT) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end else begin
            dataout_q <= mem[rd_addr];
            valid_q   <= 1'b1;
            idx       <= idx + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.dataout      = dataout_q;
  assign bus.output_valid = valid_q;
  assign bus.busy         = busy_q;
  assign bus.zoom_mode    = zoom;
endmodule

// File: tb/tb_lcd_win_ctrl.sv
// Randomized and directed checks of lcd_win_ctrl against a view-level model
// that computes each window pixel straight from origin, scale and mirror flags.
module tb_lcd_win_ctrl;
  localparam int IMG_W = 12;
  localparam int IMG_H = 9;
  localparam int WIN   = 4;
  localparam int DW    = 8;
  localparam int N     = IMG_W * IMG_H;
  localparam int NW    = WIN * WIN;
  localparam int SX    = IMG_W / WIN;
  localparam int SY    = IMG_H / WIN;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lcd_win_if #(.DW(DW)) bus ();

  lcd_win_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .WIN(WIN), .DW(DW)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  int total = 0;
  int bad = 0;
  int img[N];
  bit m_zoom, m_mh, m_mv;
  int m_ox, m_oy;
  int win_q[$];
  int ref_q[$];
  int fit_exp[NW] = '{13, 16, 19, 22, 37, 40, 43, 46, 61, 64, 67, 70, 85, 88, 91, 94};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_zoom = 0; m_mh = 0; m_mv = 0;
    m_ox = (IMG_W - WIN + 1) / 2;
    m_oy = (IMG_H - WIN + 1) / 2;
  endfunction

  function automatic void model_cmd(input int c);
    case (c)
      0: model_reset();
      1: if (!m_zoom) begin
        m_zoom = 1;
        m_ox = (IMG_W - WIN + 1) / 2;
        m_oy = (IMG_H - WIN + 1) / 2;
      end
      2: m_zoom = 0;
      3: if (m_zoom && m_ox < IMG_W - WIN) m_ox++;
      4: if (m_zoom && m_ox > 0) m_ox--;
      5: if (m_zoom && m_oy > 0) m_oy--;
      6: if (m_zoom && m_oy < IMG_H - WIN) m_oy++;
      8: m_mh = !m_mh;
      9: m_mv = !m_mv;
      default: ;
    endcase
  endfunction

  function automatic int exp_pix(input int i);
    int r, c;
    r = i / WIN;
    c = i % WIN;
    if (m_mv) r = WIN - 1 - r;
    if (m_mh) c = WIN - 1 - c;
    if (m_zoom) return img[(m_oy + r) * IMG_W + m_ox + c];
    return img[(r * SY + SY / 2) * IMG_W + c * SX + SX / 2];
  endfunction

  // drive=0: cmd_valid is already high from the previous call. hold: leave it high.
  task automatic run_cmd(input int c, input bit drive, input bit hold);
    int first;
    bit ev;
    if (drive) begin
      @(negedge clk);
      bus.cmd = 4'(c);
      bus.cmd_valid = 1'b1;
    end
    @(posedge clk);
    model_cmd(c);
    win_q.delete();
    first = (c == 0) ? N + 1 : 2;
    for (int m = 0; m <= first + NW; m++) begin
      @(negedge clk);
      if (m == 0 && !hold) bus.cmd_valid = 1'b0;
      if (c == 0 && m < N) bus.datain = DW'(img[m]);
      ev = (m >= first) && (m < first + NW);
      chk("valid", 32'(bus.output_valid), 32'(ev));
      chk("busy", 32'(bus.busy), 32'(m < first + NW));
      if (ev) begin
        chk("pix", 32'(bus.dataout), 32'(exp_pix(m - first)));
        win_q.push_back(int'(bus.dataout));
      end
    end
    chk("zoom_mode", 32'(bus.zoom_mode), 32'(m_zoom));
  endtask

  task automatic load_index();
    for (int k = 0; k < N; k++) img[k] = k;
    run_cmd(0, 1, 0);
  endtask

  initial begin
    reset = 1'b1;
    bus.cmd = '0;
    bus.cmd_valid = 1'b0;
    bus.datain = '0;
    model_reset();
    #12;
    chk("rst_valid", 32'(bus.output_valid), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_zoom", 32'(bus.zoom_mode), 0);
    chk("rst_data", 32'(bus.dataout), 0);
    @(negedge clk);
    reset = 1'b0;

    load_index();
    for (int i = 0; i < NW; i++) chk("fit_list", 32'(win_q[i]), 32'(fit_exp[i]));

    run_cmd(1, 1, 0);
    chk("zoom_first", 32'(win_q[0]), 40);
    chk("zoom_last", 32'(win_q[NW-1]), 79);
    run_cmd(1, 1, 0);
    chk("zoom_again", 32'(win_q[0]), 40);
    for (int i = 0; i < 6; i++) run_cmd(3, 1, 0);
    chk("right_sat", 32'(win_q[0]), 44);
    for (int i = 0; i < 5; i++) run_cmd(5, 1, 0);
    chk("up_sat", 32'(win_q[0]), 8);
    for (int i = 0; i < 7; i++) run_cmd(6, 1, 0);
    chk("down_sat", 32'(win_q[0]), 68);

    run_cmd(2, 1, 0);
    run_cmd(4, 1, 0);
    for (int i = 0; i < NW; i++) chk("fit_left", 32'(win_q[i]), 32'(fit_exp[i]));
    run_cmd(8, 1, 0);
    run_cmd(9, 1, 0);
    chk("mirror_first", 32'(win_q[0]), 94);
    chk("mirror_last", 32'(win_q[NW-1]), 13);
    run_cmd(7, 1, 0);
    ref_q = win_q;
    run_cmd(12, 1, 0);
    for (int i = 0; i < NW; i++) chk("cmd12", 32'(win_q[i]), 32'(ref_q[i]));

    run_cmd(2, 1, 1);
    run_cmd(2, 0, 0);
    @(negedge clk);
    chk("hold_idle", 32'(bus.busy), 0);

    run_cmd(1, 1, 0);
    @(negedge clk);
    bus.cmd = 4'd7;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (9) @(negedge clk);
    chk("pre_rst_valid", 32'(bus.output_valid), 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(bus.output_valid), 0);
    chk("mid_rst_busy", 32'(bus.busy), 0);
    chk("mid_rst_zoom", 32'(bus.zoom_mode), 0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    load_index();
    for (int i = 0; i < NW; i++) chk("reload_fit", 32'(win_q[i]), 32'(fit_exp[i]));

    for (int k = 0; k < N; k++) img[k] = int'($urandom_range(0, (1 << DW) - 1));
    run_cmd(0, 1, 0);
    for (int i = 0; i < 80; i++) run_cmd(int'($urandom_range(1, 15)), 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
